fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage pipeline: owns the PC register and the IF/ID pipeline register.
- Consumes the hazard unit's stall_f, stall_d, flush_d and PC_source plus the resolved branch target.
- Talks to instruction memory over a req/ready handshake and hands instruction, PC+1 and a valid bit to decode.
- Absorbs variable memory latency with a WAIT state and a one-entry HOLD buffer.

Parameters:
- PC_WIDTH, 8, PC and instruction-memory address width.
- INSTR_WIDTH, 16, instruction word width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- stall_f  in  1  hazard unit: freeze PC.
- stall_d  in  1  hazard unit: freeze IF/ID.
- flush_d  in  1  hazard unit: load bubble into IF/ID.
- PC_source  in  1  branch/jump taken, redirect to branch_target.
- branch_target  in  PC_WIDTH  redirect address.
- imem_adr  out  PC_WIDTH  fetch address (= pc_f).
- imem_req  out  1  fetch request.
- imem_data  in  INSTR_WIDTH  instruction, valid when imem_ready=1.
- imem_ready  in  1  memory completes the current request this cycle.
- instr_d  out  INSTR_WIDTH  IF/ID instruction.
- PC_plus1_d  out  PC_WIDTH  IF/ID PC+1 of that instruction.
- valid_d  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_busy  out  1  high while in WAIT; the hazard unit ORs it into its stalls.

Behaviour:
- Reset (async, immediate):
  - pc_f=RESET_PC, state=FETCH, pend=0, hold buffer cleared.
  - instr_d=0, PC_plus1_d=0, valid_d=0.
  - imem_req forced 0 while reset is high.
  - Reset mid-WAIT abandons the outstanding request; a late imem_ready is ignored.
- stall = stall_f | stall_d. The hazard unit drives both together; the block must not rely on that.
- Handshake:
  - imem_req = !reset && state!=HOLD.
  - imem_adr and imem_req stay stable from request until imem_ready.
  - Zero-wait memory (imem_ready tied 1) gives one instruction per cycle.
- States:
  - FETCH: request issued.
    - imem_ready=0 -> WAIT.
    - imem_ready=1 -> instruction available (avail).
  - WAIT: same address re-requested.
    - imem_ready=1 -> avail (or dropped if pend), then back to FETCH.
  - HOLD: buffered instruction is avail; no request issued.
    - Leave to FETCH when the buffer is consumed or killed.
- Consumption when avail and !stall:
  - IF/ID <= {instr, pc_f+1, valid=1}, unless flush_d or PC_source is high that cycle, in which case IF/ID gets a bubble.
  - pc_f <= PC_source ? branch_target : pc_f+1.
- Consumption when avail and stall:
  - From memory: capture {instr, pc_f} into the hold buffer, go to HOLD; pc_f unchanged.
  - Already in HOLD: stay.
- Redirect priority for the PC: reset > PC_source > stall > increment.
  - PC_source in FETCH or HOLD: pc_f <= branch_target next cycle; hold buffer dropped; state FETCH.
  - PC_source in WAIT: latch branch_target into redirect_pc, set pend; pc_f and imem_adr keep the old address.
    - On imem_ready: drop the data, pc_f <= redirect_pc, pend <= 0, state FETCH.
    - A second PC_source while pend is set overwrites redirect_pc.
- IF/ID priority: reset > flush_d > stall_d (hold) > load.
  - No avail and !stall_d: load bubble (valid_d=0, instr_d and PC_plus1_d keep their old values).
- Width rules:
  - pc_f+1 wraps modulo 2^PC_WIDTH (255 -> 0 at default width).
  - PC_plus1_d carries the wrapped value.
- fetch_busy = (state==WAIT), combinational from the state register.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
  - Defined: adds outputs wait_cycles[15:0] and redirect_cnt[15:0].
    - wait_cycles counts cycles in WAIT; redirect_cnt counts cycles with PC_source=1.
    - Both saturate at 16'hFFFF and clear on reset.
  - Undefined: neither port nor any counter logic exists; behaviour otherwise identical.

Test Plan:
- Reset release, imem_ready=1, imem_data=16'hA000+adr, no stalls -> imem_adr 0,1,2,3 on successive cycles; instr_d A000,A001,A002 with valid_d=1 and PC_plus1_d 1,2,3.
- imem_ready low 3 cycles at adr 4 -> fetch_busy=1 for 3 cycles; imem_adr held at 4; valid_d=0 bubbles; then instr_d=A004, PC_plus1_d=5.
- stall_f=stall_d=1 for 2 cycles with data ready at adr 6 -> imem_req=0 in HOLD; IF/ID frozen; after release instr_d=A006 loaded once; next imem_adr=7.
- PC_source=1, branch_target=8'h40 in FETCH at adr 9 -> valid_d=0 next cycle; imem_adr=40; then instr_d=A040.
- PC_source=1, target 8'h20 during WAIT at adr 12, imem_ready two cycles later -> data for 12 never reaches IF/ID; imem_adr=20 after the ready; flush_d pulse gives valid_d=0.
- Start at RESET_PC=8'hFE -> PC_plus1_d FF then 00; imem_adr wraps to 0. Also assert reset mid-WAIT -> outputs zero immediately; late imem_ready ignored.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
//   adr   : fetch address, held stable from request until ready
//   req   : fetch request
//   data  : instruction word, valid when ready=1
//   ready : memory completes the current request this cycle
// modport master = fetch stage, modport slave = instruction memory.
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic [PC_WIDTH-1:0]    adr;
  logic                   req;
  logic [INSTR_WIDTH-1:0] data;
  logic                   ready;

  modport master (output adr, output req, input data, input ready);
  modport slave  (input adr, input req, output data, output ready);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC and the IF/ID pipeline register.
// Absorbs variable imem latency with a WAIT state and keeps a one-entry HOLD
// buffer for an instruction that arrives while the pipeline is stalled.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   stall_f, stall_d      : hazard unit freezes for PC and IF/ID
//   flush_d               : load a bubble into IF/ID
//   PC_source, branch_target : taken branch/jump and its target
//   imem (master)         : instruction memory req/ready bus
//   instr_d, PC_plus1_d, valid_d : IF/ID register contents
//   fetch_busy            : high while waiting on memory
// Optional: define FETCH_PERF_CNT_EN to add the wait_cycles and
// redirect_cnt saturating counters as outputs.
module fetch_stage #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_f,
  input  logic                   stall_d,
  input  logic                   flush_d,
  input  logic                   PC_source,
  input  logic [PC_WIDTH-1:0]    branch_target,
  fetch_stage_if.master          imem,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [PC_WIDTH-1:0]    PC_plus1_d,
  output logic                   valid_d,
  output logic                   fetch_busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]            wait_cycles,
  output logic [15:0]            redirect_cnt
`endif
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   pend_q, pend_d;
  logic [PC_WIDTH-1:0]    redir_q, redir_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]    ifid_p1_q, ifid_p1_d;
  logic                   ifid_vld_q, ifid_vld_d;

  logic                   stall, mem_done, drop, avail;
  logic [INSTR_WIDTH-1:0] avail_instr;
  logic [PC_WIDTH-1:0]    pc_inc;

  // While in HOLD, pc_q still points at the buffered instruction, so the
  // buffer only needs the instruction word itself.
  always_comb begin
    stall       = stall_f | stall_d;
    mem_done    = (state_q != S_HOLD) && imem.ready;
    drop        = mem_done && pend_q;             // data for an abandoned address
    avail       = (state_q == S_HOLD) || (mem_done && !pend_q);
    avail_instr = (state_q == S_HOLD) ? hold_instr_q : imem.data;
    pc_inc      = pc_q + PC_WIDTH'(1);            // wraps modulo 2^PC_WIDTH
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    redir_d      = redir_q;
    hold_instr_d = hold_instr_q;
    if (drop) begin
      // A redirect arriving together with the completion wins over the latched one.
      pc_d    = PC_source ? branch_target : redir_q;
      pend_d  = 1'b0;
      state_d = S_FETCH;
    end else if (PC_source) begin
      if (state_q == S_WAIT && !imem.ready) begin
        // Address must stay stable until memory answers: defer the redirect.
        redir_d = branch_target;
        pend_d  = 1'b1;
      end else begin
        pc_d    = branch_target;
        state_d = S_FETCH;
      end
    end else if (avail) begin
      if (!stall) begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end else if (state_q != S_HOLD) begin
        hold_instr_d = imem.data;
        state_d      = S_HOLD;
      end
    end else begin
      state_d = S_WAIT;
    end
  end

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_p1_d    = ifid_p1_q;
    ifid_vld_d   = ifid_vld_q;
    if (flush_d) begin
      ifid_vld_d = 1'b0;
    end else if (stall_d) begin
      ifid_vld_d = ifid_vld_q;
    end else if (avail && !stall && !PC_source) begin
      ifid_instr_d = avail_instr;
      ifid_p1_d    = pc_inc;
      ifid_vld_d   = 1'b1;
    end else begin
      ifid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      redir_q      <= '0;
      hold_instr_q <= '0;
      ifid_instr_q <= '0;
      ifid_p1_q    <= '0;
      ifid_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      redir_q      <= redir_d;
      hold_instr_q <= hold_instr_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_p1_q    <= ifid_p1_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

  assign imem.adr   = pc_q;
  assign imem.req   = !reset && (state_q != S_HOLD);
  assign fetch_busy = (state_q == S_WAIT);
  assign instr_d    = ifid_instr_q;
  assign PC_plus1_d = ifid_p1_q;
  assign valid_d    = ifid_vld_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (state_q == S_WAIT && wait_cnt_q != 16'hFFFF) wait_cnt_d = wait_cnt_q + 16'd1;
    if (PC_source && redir_cnt_q != 16'hFFFF)        redir_cnt_d = redir_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      redir_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign wait_cycles  = wait_cnt_q;
  assign redirect_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic       clk = 1'b0;
  logic       reset, reset2;
  logic       stall_f, stall_d, flush_d, ps;
  logic [7:0] bt;
  logic       ready;

  logic [15:0] instr_d, instr_d2;
  logic [7:0]  p1_d, p1_d2;
  logic        valid_d, valid_d2, busy, busy2;

  int cmp_n = 0;
  int err_n = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus  ();
  fetch_stage_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus2 ();

  // Instruction memory: word at address a is 16'hA000 + a.
  assign bus.data   = 16'hA000 + {8'h00, bus.adr};
  assign bus.ready  = ready;
  assign bus2.data  = 16'hA000 + {8'h00, bus2.adr};
  assign bus2.ready = 1'b1;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] wc, rc, wc2, rc2;
`endif

  fetch_stage #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .PC_source(ps), .branch_target(bt), .imem(bus),
    .instr_d(instr_d), .PC_plus1_d(p1_d), .valid_d(valid_d), .fetch_busy(busy)
`ifdef FETCH_PERF_CNT_EN
    , .wait_cycles(wc), .redirect_cnt(rc)
`endif
  );

  fetch_stage #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'hFE)) u_dut2 (
    .clk(clk), .reset(reset2), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .PC_source(ps), .branch_target(bt), .imem(bus2),
    .instr_d(instr_d2), .PC_plus1_d(p1_d2), .valid_d(valid_d2), .fetch_busy(busy2)
`ifdef FETCH_PERF_CNT_EN
    , .wait_cycles(wc2), .redirect_cnt(rc2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_out  : a request has been issued and is still unanswered
  // m_buf  : instruction parked while the pipeline was stalled
  // m_pend : redirect target waiting for the outstanding request to finish
  logic [7:0]  m_pc;
  bit          m_out;
  logic [15:0] m_buf[$];
  logic [7:0]  m_pend[$];
  logic [15:0] m_instr;
  logic [7:0]  m_p1;
  bit          m_valid;

  always @(negedge clk) begin
    bit holding, got, dropped, have, stl;
    logic [15:0] word;
    if (reset) begin
      m_pc = 8'h00; m_out = 0; m_buf.delete(); m_pend.delete();
      m_instr = '0; m_p1 = '0; m_valid = 0;
    end
    chk("imem_adr",   {24'h0, bus.adr},  {24'h0, m_pc});
    chk("imem_req",   {31'h0, bus.req},  {31'h0, (!reset && m_buf.size() == 0)});
    chk("fetch_busy", {31'h0, busy},     {31'h0, m_out});
    chk("instr_d",    {16'h0, instr_d},  {16'h0, m_instr});
    chk("PC_plus1_d", {24'h0, p1_d},     {24'h0, m_p1});
    chk("valid_d",    {31'h0, valid_d},  {31'h0, m_valid});
    if (!reset) begin
      holding = (m_buf.size() > 0);
      got     = !holding && ready;
      dropped = got && (m_pend.size() > 0);
      have    = holding || (got && !dropped);
      word    = holding ? m_buf[0] : (16'hA000 + {8'h00, m_pc});
      stl     = stall_f | stall_d;
      // IF/ID
      if (flush_d) m_valid = 0;
      else if (stall_d) ;
      else if (have && !stl && !ps) begin
        m_instr = word; m_p1 = m_pc + 8'd1; m_valid = 1;
      end else m_valid = 0;
      // PC / fetch progress
      if (dropped) begin
        m_pc = ps ? bt : m_pend[0];
        m_pend.delete(); m_out = 0;
      end else if (ps) begin
        if (m_out && !ready) begin
          m_pend.delete(); m_pend.push_back(bt);
        end else begin
          m_pc = bt; m_buf.delete(); m_out = 0;
        end
      end else if (have) begin
        if (!stl) begin
          m_pc = m_pc + 8'd1; m_buf.delete(); m_out = 0;
        end else if (!holding) begin
          m_buf.push_back(word); m_out = 0;
        end
      end else m_out = 1;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic lit(input string tag, input logic [15:0] ei, input logic [7:0] ep,
                     input logic ev, input logic [7:0] ea);
    chk({tag, ".instr_d"},    {16'h0, instr_d}, {16'h0, ei});
    chk({tag, ".PC_plus1_d"}, {24'h0, p1_d},    {24'h0, ep});
    chk({tag, ".valid_d"},    {31'h0, valid_d}, {31'h0, ev});
    chk({tag, ".imem_adr"},   {24'h0, bus.adr}, {24'h0, ea});
  endtask

  initial begin
    reset = 1; reset2 = 1; stall_f = 0; stall_d = 0; flush_d = 0; ps = 0; bt = 0; ready = 1;
    cyc(); cyc();
    lit("reset", 16'h0, 8'h0, 1'b0, 8'h00);
    reset = 0;
    // straight-line fetch
    cyc(); lit("seq0", 16'hA000, 8'h01, 1'b1, 8'h01);
    cyc(); lit("seq1", 16'hA001, 8'h02, 1'b1, 8'h02);
    cyc(); lit("seq2", 16'hA002, 8'h03, 1'b1, 8'h03);
    cyc(); lit("seq3", 16'hA003, 8'h04, 1'b1, 8'h04);
    // three cycles of memory latency at adr 4
    ready = 0;
    cyc(); lit("wait1", 16'hA003, 8'h04, 1'b0, 8'h04); chk("wait1.busy", {31'h0, busy}, 32'd1);
    cyc(); cyc();
    ready = 1;
    cyc(); lit("wait_done", 16'hA004, 8'h05, 1'b1, 8'h05); chk("wait_done.busy", {31'h0, busy}, 32'd0);
    cyc(); lit("pre_stall", 16'hA005, 8'h06, 1'b1, 8'h06);
    // stall two cycles with data ready at adr 6
    stall_f = 1; stall_d = 1;
    cyc(); lit("hold1", 16'hA005, 8'h06, 1'b1, 8'h06); chk("hold1.req", {31'h0, bus.req}, 32'd0);
    cyc(); lit("hold2", 16'hA005, 8'h06, 1'b1, 8'h06);
    stall_f = 0; stall_d = 0;
    cyc(); lit("unhold", 16'hA006, 8'h07, 1'b1, 8'h07); chk("unhold.req", {31'h0, bus.req}, 32'd1);
    cyc(); cyc(); lit("at9", 16'hA008, 8'h09, 1'b1, 8'h09);
    // branch taken in FETCH
    ps = 1; bt = 8'h40;
    cyc(); lit("br", 16'hA008, 8'h09, 1'b0, 8'h40);
    ps = 0;
    cyc(); lit("br_tgt", 16'hA040, 8'h41, 1'b1, 8'h41);
    ps = 1; bt = 8'h0C;
    cyc(); lit("br12", 16'hA040, 8'h41, 1'b0, 8'h0C);
    // redirect during WAIT at adr 12
    ps = 0; ready = 0;
    cyc();
    ps = 1; bt = 8'h20;
    cyc(); lit("pend", 16'hA040, 8'h41, 1'b0, 8'h0C);
    ps = 0;
    cyc();
    ready = 1;
    cyc(); lit("pend_drop", 16'hA040, 8'h41, 1'b0, 8'h20);
    flush_d = 1;
    cyc(); lit("flush", 16'hA040, 8'h41, 1'b0, 8'h21);
    flush_d = 0;
    cyc(); lit("post_flush", 16'hA021, 8'h22, 1'b1, 8'h22);
    // PC wrap
    ps = 1; bt = 8'hFE;
    cyc(); ps = 0;
    cyc(); lit("wrapFE", 16'hA0FE, 8'hFF, 1'b1, 8'hFF);
    cyc(); lit("wrapFF", 16'hA0FF, 8'h00, 1'b1, 8'h00);
    // mixed directed pattern, checked by the model
    for (int i = 0; i < 48; i++) begin
      ready   = (i % 5) != 2;
      stall_f = (i % 7) == 3;
      stall_d = ((i % 7) == 3) || ((i % 11) == 5);
      ps      = (i % 13) == 6;
      flush_d = (i % 17) == 9;
      bt      = 8'(i * 3);
      cyc();
    end
    // reset in the middle of WAIT
    stall_f = 0; stall_d = 0; ps = 0; flush_d = 0; ready = 0;
    cyc(); cyc(); cyc();
    chk("midwait.busy", {31'h0, busy}, 32'd1);
    reset = 1; ready = 1;
    #1;
    lit("rst_now", 16'h0, 8'h0, 1'b0, 8'h00);
    chk("rst_now.req",  {31'h0, bus.req}, 32'd0);
    chk("rst_now.busy", {31'h0, busy},    32'd0);
    cyc(); reset = 0;
    cyc(); lit("after_rst", 16'hA000, 8'h01, 1'b1, 8'h01);
    // RESET_PC = FE instance
    reset2 = 0;
    #1 chk("r2.adr0", {24'h0, bus2.adr}, 32'hFE);
    cyc();
    chk("r2.p1a",  {24'h0, p1_d2},    32'hFF);
    chk("r2.ins",  {16'h0, instr_d2}, 32'hA0FE);
    chk("r2.adr1", {24'h0, bus2.adr}, 32'hFF);
    cyc();
    chk("r2.p1b",  {24'h0, p1_d2},    32'h00);
    chk("r2.vld",  {31'h0, valid_d2}, 32'd1);
    chk("r2.adr2", {24'h0, bus2.adr}, 32'h00);
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
